// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the word-wide data memory.
// It takes one request at a time and decodes funct3. Sub-word stores are
// done as read-modify-write. Load data is extracted and extended, and bad
// accesses are flagged. Each request gets one response on a valid/ready port.
module lsu_ctrl #(
    parameter int REG_WIDTH       = 32,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int DMEM_DEPTH      = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [2:0]                 req_funct3,
    input  logic [REG_WIDTH-1:0]       req_addr,
    input  logic [REG_WIDTH-1:0]       req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [REG_WIDTH-1:0]       rsp_data,
    output logic                       rsp_err,
    output logic                       dmem_wr_en,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [REG_WIDTH-1:0]       dmem_wr_data,
    input  logic [REG_WIDTH-1:0]       dmem_rd_data
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    // Only the request fields needed after acceptance are kept. The full
    // address is consumed at acceptance (range check, memory address).
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [15:0] wdata;
    } lsu_req_t;

    state_t   state;
    lsu_req_t req_q;

    logic               f3_bad;
    logic               misalign;
    logic               out_of_range;
    logic               req_err;
    logic [REG_WIDTH:0] word_end;

    // Select byte/halfword lane from the memory word and extend it.
    function automatic logic [REG_WIDTH-1:0] load_ext(input logic [REG_WIDTH-1:0] w,
                                                      input logic [2:0] f3,
                                                      input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = 16'(w >> {off[1], 4'b0000});
        case (f3)
            3'b000:  return {{(REG_WIDTH-8){b[7]}}, b};
            3'b001:  return {{(REG_WIDTH-16){h[15]}}, h};
            3'b100:  return {{(REG_WIDTH-8){1'b0}}, b};
            3'b101:  return {{(REG_WIDTH-16){1'b0}}, h};
            default: return w;
        endcase
    endfunction

    // Replace one byte (SB) or halfword (SH) lane of the read word.
    function automatic logic [REG_WIDTH-1:0] merge(input logic [REG_WIDTH-1:0] w,
                                                   input logic [1:0] f3lo,
                                                   input logic [1:0] off,
                                                   input logic [15:0] wd);
        logic [REG_WIDTH-1:0] mask;
        logic [REG_WIDTH-1:0] data;
        if (f3lo == 2'b00) begin
            mask = REG_WIDTH'(8'hFF) << {off, 3'b000};
            data = REG_WIDTH'(wd[7:0]) << {off, 3'b000};
        end else begin
            mask = REG_WIDTH'(16'hFFFF) << {off[1], 4'b0000};
            data = REG_WIDTH'(wd) << {off[1], 4'b0000};
        end
        return (w & ~mask) | (data & mask);
    endfunction

    // Decode the incoming request's error conditions; any one of them
    // sends the request straight to RESP without touching memory.
    always_comb begin
        if (req_we)
            f3_bad = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            f3_bad = (req_funct3[1:0] == 2'b11) || (req_funct3[2:1] == 2'b11);
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        // Computed one bit wider so high addresses cannot wrap into range.
        word_end     = {1'b0, req_addr[REG_WIDTH-1:2], 2'b00} + (REG_WIDTH+1)'(3);
        out_of_range = (word_end >= (REG_WIDTH+1)'(DMEM_DEPTH));
        req_err      = f3_bad || misalign || out_of_range;
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_q        <= '0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            dmem_wr_en   <= 1'b0;
            dmem_addr    <= '0;
            dmem_wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q     <= '{we: req_we, funct3: req_funct3,
                                       off: req_addr[1:0], wdata: req_wdata[15:0]};
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                        end else begin
                            dmem_addr <= {req_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
                            if (req_we && (req_funct3[1:0] == 2'b10)) begin
                                // Full-word store needs no read.
                                state        <= WRITE;
                                dmem_wr_en   <= 1'b1;
                                dmem_wr_data <= req_wdata;
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (req_q.we) begin
                        state        <= WRITE;
                        dmem_wr_en   <= 1'b1;
                        dmem_wr_data <= merge(dmem_rd_data, req_q.funct3[1:0],
                                              req_q.off, req_q.wdata);
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= load_ext(dmem_rd_data, req_q.funct3, req_q.off);
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    dmem_wr_en <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= 1'b0;
                    rsp_data   <= '0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
